// File: rtl/prio_pkg.sv
// prio_pkg: shared state type, mode constants and clog2 helper for the priority arbiter
package prio_pkg;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR = 1'b1;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/prio_find_first.sv
// prio_find_first: first set bit of vec searching upward from start with wrap at N-1
module prio_find_first import prio_pkg::*; #(
   parameter int N = 8,
   localparam int W = (clog2(N) > 1) ? clog2(N) : 1
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);
   logic [W-1:0] w_pos;
   // scan offsets farthest first so the nearest set bit at or after start is written last
   always_comb begin
      found = 1'b0;
      idx = '0;
      w_pos = '0;
      for (int i = N - 1; i >= 0; i--) begin
         w_pos = W'((int'(start) + i) % N);
         if (vec[w_pos]) begin
            found = 1'b1;
            idx = w_pos;
         end
      end
   end
endmodule

// File: rtl/priority_arbiter.sv
// priority_arbiter: registered fixed/round-robin arbiter with valid/ready grant handshake
module priority_arbiter import prio_pkg::*; #(
   parameter int N = 8,
   localparam int W = (clog2(N) > 1) ? clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot
);
   state_t       r_state, w_state_nxt;
   logic [W-1:0] r_ptr, r_idx, w_ptr_nxt, w_start, w_idx, w_idx_nxt;
   logic [N-1:0] r_onehot, w_onehot_nxt;
   logic         w_arb, w_accept, w_found;

   assign w_accept = (r_state == GRANT) && out_ready;
   assign w_arb = (r_state == IDLE) || out_ready;
   // the pointer advance of an accept is already visible to the arbitration in the same cycle
   assign w_ptr_nxt = w_accept ? ((r_idx == W'(N - 1)) ? '0 : r_idx + W'(1)) : r_ptr;
   assign w_start = (mode == MODE_FIXED) ? '0 : w_ptr_nxt;

   prio_find_first #(.N(N)) u_find (
      .vec(req),
      .start(w_start),
      .found(w_found),
      .idx(w_idx)
   );

   // next state and grant: only an arbitration cycle may change what is presented
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt = r_idx;
      w_onehot_nxt = r_onehot;
      if (w_arb) begin
         w_state_nxt = w_found ? GRANT : IDLE;
         w_idx_nxt = w_found ? w_idx : '0;
         w_onehot_nxt = w_found ? (N'(1) << w_idx) : '0;
      end
   end

   // state, pointer and output registers; reset drops a pending grant without accepting it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr <= '0;
         r_idx <= '0;
         r_onehot <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr <= w_ptr_nxt;
         r_idx <= w_idx_nxt;
         r_onehot <= w_onehot_nxt;
      end
   end

   assign out_valid = (r_state == GRANT);
   assign out_idx = r_idx;
   assign out_onehot = r_onehot;
endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: directed vector table for N=8 plus a round-robin wrap sequence for N=5
module tb_priority_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req8 = '0;
   logic       mode8 = 1'b0, rdy8 = 1'b0, v8;
   logic [2:0] i8;
   logic [7:0] oh8;
   logic [4:0] req5 = '0;
   logic       mode5 = 1'b0, rdy5 = 1'b0, v5;
   logic [2:0] i5;
   logic [4:0] oh5;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   priority_arbiter #(.N(8)) u8 (
      .clk(clk), .rst(rst), .req(req8), .mode(mode8), .out_valid(v8),
      .out_ready(rdy8), .out_idx(i8), .out_onehot(oh8)
   );

   priority_arbiter #(.N(5)) u5 (
      .clk(clk), .rst(rst), .req(req5), .mode(mode5), .out_valid(v5),
      .out_ready(rdy5), .out_idx(i5), .out_onehot(oh5)
   );

   typedef struct {
      logic       r;
      logic [7:0] req;
      logic       m;
      logic       rdy;
      logic       ev;
      logic [2:0] ei;
   } vec_t;

   vec_t tbl [35];

   task automatic chk(input string nm, input logic av, input logic [2:0] ai, input logic [7:0] aoh,
                      input logic ev, input logic [2:0] ei, input logic [7:0] eoh);
      checks++;
      if (av !== ev || ai !== ei || aoh !== eoh) begin
         errors++;
         $display("FAIL %s: got valid=%0b idx=%0d onehot=%b, expected valid=%0b idx=%0d onehot=%b",
                  nm, av, ai, aoh, ev, ei, eoh);
      end
   endtask

   task automatic step5(input string nm, input logic r, input logic [4:0] rq, input logic m,
                        input logic rdy, input logic ev, input logic [2:0] ei);
      logic [7:0] eoh;
      rst = r;
      req5 = rq;
      mode5 = m;
      rdy5 = rdy;
      @(posedge clk);
      #1;
      eoh = ev ? (8'h1 << ei) : 8'h0;
      chk(nm, v5, i5, {3'b000, oh5}, ev, ei, eoh);
   endtask

   initial begin
      logic [7:0] eoh;
      tbl[0]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[3]  = '{1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 3'd7};
      tbl[4]  = '{1'b0, 8'hA4, 1'b0, 1'b1, 1'b1, 3'd2};
      tbl[5]  = '{1'b0, 8'hA4, 1'b0, 1'b1, 1'b1, 3'd2};
      tbl[6]  = '{1'b0, 8'hA4, 1'b0, 1'b1, 1'b1, 3'd2};
      tbl[7]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0};
      for (int k = 0; k < 9; k++) tbl[8 + k] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'(k % 8)};
      tbl[17] = '{1'b0, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5};
      tbl[18] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 3'd5};
      tbl[19] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 3'd5};
      tbl[20] = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 3'd5};
      tbl[21] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 3'd5};
      tbl[22] = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 3'd0};
      tbl[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0};
      tbl[24] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[25] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[26] = '{1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 3'd2};
      tbl[27] = '{1'b0, 8'h40, 1'b0, 1'b1, 1'b1, 3'd6};
      tbl[28] = '{1'b0, 8'h40, 1'b0, 1'b0, 1'b1, 3'd6};
      tbl[29] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0};
      tbl[30] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd0};
      tbl[31] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd0};
      tbl[32] = '{1'b0, 8'h0C, 1'b1, 1'b1, 1'b1, 3'd2};
      tbl[33] = '{1'b0, 8'h0C, 1'b1, 1'b1, 1'b1, 3'd3};
      tbl[34] = '{1'b0, 8'h0C, 1'b1, 1'b1, 1'b1, 3'd2};
      for (int k = 0; k < 35; k++) begin
         rst = tbl[k].r;
         req8 = tbl[k].req;
         mode8 = tbl[k].m;
         rdy8 = tbl[k].rdy;
         @(posedge clk);
         #1;
         eoh = tbl[k].ev ? (8'h1 << tbl[k].ei) : 8'h0;
         chk($sformatf("n8_row%0d", k), v8, i8, oh8, tbl[k].ev, tbl[k].ei, eoh);
      end
      step5("n5_reset",      1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0);
      step5("n5_first",      1'b0, 5'b01000, 1'b1, 1'b1, 1'b1, 3'd3);
      step5("n5_wrap_ptr4",  1'b0, 5'b00011, 1'b1, 1'b1, 1'b1, 3'd0);
      step5("n5_ptr1",       1'b0, 5'b00011, 1'b1, 1'b1, 1'b1, 3'd1);
      step5("n5_ptr2_wrap",  1'b0, 5'b00011, 1'b1, 1'b1, 1'b1, 3'd0);
      step5("n5_top",        1'b0, 5'b10000, 1'b1, 1'b1, 1'b1, 3'd4);
      step5("n5_ptr_wrap0",  1'b0, 5'b00001, 1'b1, 1'b1, 1'b1, 3'd0);
      step5("n5_fixed",      1'b0, 5'b00010, 1'b0, 1'b1, 1'b1, 3'd1);
      step5("n5_idle",       1'b0, 5'b00000, 1'b0, 1'b1, 1'b0, 3'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
